// File: rtl/block_code_a20_decoder.sv
// Soft-decision ML decoder for the (20,A) PUCCH/CQI block code, A = 1..13.
// Optional macro A20_TLAST_CHECK_EN adds the frame_err port and tlast framing checks.
module block_code_a20_decoder #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_SYMBOLS = 20
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [3:0]            code_length,
  input  logic                  code_length_valid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic                  m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
`ifdef A20_TLAST_CHECK_EN
  ,
  output logic                  frame_err
`endif
);

  localparam int MW = DATA_WIDTH + 5;
  localparam logic [4:0] LAST_BEAT = 5'(NUM_SYMBOLS - 1);

  // Basis rows M_i,0..M_i,12; the leftmost literal bit is column 0.
  localparam logic [0:12] BASIS [20] = '{
    13'b1100000000110, 13'b1110000001110, 13'b1001001011111, 13'b1011000010111,
    13'b1111000100111, 13'b1100101110111, 13'b1010101011111, 13'b1001100110111,
    13'b1101100101111, 13'b1011101001111, 13'b1010011101111, 13'b1110011010111,
    13'b1001010111111, 13'b1101010101111, 13'b1000110100101, 13'b1100111101101,
    13'b1110111001011, 13'b1001110010011, 13'b1101111100000, 13'b1000011000000
  };

  typedef enum logic [1:0] {IDLE, LOAD, SEARCH, OUTPUT} state_e;

  state_e                       state_q;
  logic signed [DATA_WIDTH-1:0] llr_q [NUM_SYMBOLS];
  logic [4:0]                   beatCnt_q;
  logic [3:0]                   codeLen_q;
  logic [12:0]                  cand_q;
  logic [12:0]                  bestMsg_q;
  logic signed [MW-1:0]         bestMetric_q;
  logic [3:0]                   bitIdx_q;
  logic                         tready_q;
  logic                         tvalid_q;
  logic                         tdata_q;
  logic                         tlast_q;

  logic signed [MW-1:0]         metric;
  logic signed [MW-1:0]         term;
  logic                         cwBit;
  logic [12:0]                  candMax;
  logic                         takeCand;
  logic [12:0]                  bestMsg_d;
  logic                         beatAccept;
  logic                         lastBeat;
  logic                         abortBeat;
  logic                         lenAccept;

  // Correlation of the current candidate's codeword against the stored LLRs.
  always_comb begin
    metric = '0;
    term   = '0;
    cwBit  = 1'b0;
    for (int i = 0; i < NUM_SYMBOLS; i++) begin
      cwBit = 1'b0;
      for (int n = 0; n < 13; n++) begin
        cwBit = cwBit ^ (cand_q[n] & BASIS[i][n]);
      end
      term   = {{5{llr_q[i][DATA_WIDTH-1]}}, llr_q[i]};
      metric = cwBit ? (metric - term) : (metric + term);
    end
  end

  assign candMax    = 13'((14'd1 << codeLen_q) - 14'd1);
  assign takeCand   = (cand_q == '0) || (metric > bestMetric_q);
  assign bestMsg_d  = takeCand ? cand_q : bestMsg_q;
  assign beatAccept = (state_q == LOAD) && tready_q && s_axis_tvalid;
  assign lastBeat   = (beatCnt_q == LAST_BEAT);
  assign lenAccept  = code_length_valid && (code_length != 4'd0) && (code_length <= 4'd13)
                      && ((state_q == IDLE) || (state_q == LOAD)) && (beatCnt_q == 5'd0);

`ifdef A20_TLAST_CHECK_EN
  logic frameErr_q;
  assign abortBeat = s_axis_tlast && !lastBeat;
  assign frame_err = frameErr_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      frameErr_q <= 1'b0;
    end else begin
      frameErr_q <= beatAccept && (s_axis_tlast != lastBeat);
    end
  end
`else
  logic unusedTlast;
  assign abortBeat   = 1'b0;
  assign unusedTlast = s_axis_tlast;
`endif

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q      <= IDLE;
      for (int i = 0; i < NUM_SYMBOLS; i++) llr_q[i] <= '0;
      beatCnt_q    <= '0;
      codeLen_q    <= 4'd13;
      cand_q       <= '0;
      bestMsg_q    <= '0;
      bestMetric_q <= '0;
      bitIdx_q     <= '0;
      tready_q     <= 1'b0;
      tvalid_q     <= 1'b0;
      tdata_q      <= 1'b0;
      tlast_q      <= 1'b0;
    end else begin
      if (lenAccept) codeLen_q <= code_length;
      case (state_q)
        IDLE: begin
          state_q   <= LOAD;
          tready_q  <= 1'b1;
          beatCnt_q <= '0;
        end
        LOAD: begin
          if (beatAccept) begin
            llr_q[beatCnt_q] <= s_axis_tdata;
            if (abortBeat) begin
              beatCnt_q <= '0;
            end else if (lastBeat) begin
              beatCnt_q <= '0;
              tready_q  <= 1'b0;
              cand_q    <= '0;
              state_q   <= SEARCH;
            end else begin
              beatCnt_q <= beatCnt_q + 5'd1;
            end
          end
        end
        SEARCH: begin
          bestMsg_q <= bestMsg_d;
          if (takeCand) bestMetric_q <= metric;
          if (cand_q == candMax) begin
            state_q  <= OUTPUT;
            tvalid_q <= 1'b1;
            tdata_q  <= bestMsg_d[0];
            tlast_q  <= (codeLen_q == 4'd1);
            bitIdx_q <= '0;
          end else begin
            cand_q <= cand_q + 13'd1;
          end
        end
        OUTPUT: begin
          // Data and last only advance on a handshake so they stay stable under backpressure.
          if (m_axis_tready) begin
            if (tlast_q) begin
              tvalid_q <= 1'b0;
              tdata_q  <= 1'b0;
              tlast_q  <= 1'b0;
              tready_q <= 1'b1;
              state_q  <= LOAD;
            end else begin
              bitIdx_q <= bitIdx_q + 4'd1;
              tdata_q  <= bestMsg_q[bitIdx_q + 4'd1];
              tlast_q  <= ((bitIdx_q + 4'd2) == codeLen_q);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_axis_tready = tready_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_block_code_a20_decoder.sv
// Scoreboard testbench for block_code_a20_decoder: random/directed frames vs a
// behavioural ML reference model; a monitor pops expected bits on every output handshake.
module tb_block_code_a20_decoder;

  localparam logic [0:12] BASIS [20] = '{
    13'b1100000000110, 13'b1110000001110, 13'b1001001011111, 13'b1011000010111,
    13'b1111000100111, 13'b1100101110111, 13'b1010101011111, 13'b1001100110111,
    13'b1101100101111, 13'b1011101001111, 13'b1010011101111, 13'b1110011010111,
    13'b1001010111111, 13'b1101010101111, 13'b1000110100101, 13'b1100111101101,
    13'b1110111001011, 13'b1001110010011, 13'b1101111100000, 13'b1000011000000
  };

  typedef struct packed {
    logic data;
    logic last;
  } expBeat_t;

  logic       clk;
  logic       arst;
  logic [3:0] codeLength;
  logic       codeLengthValid;
  logic [7:0] sTdata;
  logic       sTvalid;
  logic       sReady;
  logic       sTlast;
  logic       mTdata;
  logic       mTvalid;
  logic       mReady;
  logic       mTlast;
`ifdef A20_TLAST_CHECK_EN
  logic       frameErr;
`endif

  int         errors = 0;
  int         checks = 0;
  int         benchA = 13;
  int         readyMode = 0;
  int         readyPhase = 0;
  int         frameLlr [20];
  expBeat_t   expQ [$];
  logic       prevPending = 1'b0;
  logic       prevData = 1'b0;
  logic       prevLast = 1'b0;

  block_code_a20_decoder #(.DATA_WIDTH(8), .NUM_SYMBOLS(20)) dut (
    .clk              (clk),
    .arst             (arst),
    .code_length      (codeLength),
    .code_length_valid(codeLengthValid),
    .s_axis_tdata     (sTdata),
    .s_axis_tvalid    (sTvalid),
    .s_axis_tready    (sReady),
    .s_axis_tlast     (sTlast),
    .m_axis_tdata     (mTdata),
    .m_axis_tvalid    (mTvalid),
    .m_axis_tready    (mReady),
    .m_axis_tlast     (mTlast)
`ifdef A20_TLAST_CHECK_EN
    ,
    .frame_err        (frameErr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got timeout expected DUT response", name);
  endtask

  // Codeword bit i of message m, straight from the basis table with integer arithmetic.
  function automatic int codeBit(input int m, input int i);
    int s;
    s = 0;
    for (int n = 0; n < 13; n++) s += ((m >> n) & 1) * int'(BASIS[i][n]);
    return s % 2;
  endfunction

  // Exhaustive ML reference: highest correlation wins, earliest message on ties.
  function automatic int modelDecode(input int a);
    int best, bestMetric, metric;
    best = 0;
    bestMetric = 0;
    for (int m = 0; m < (1 << a); m++) begin
      metric = 0;
      for (int i = 0; i < 20; i++) metric += (codeBit(m, i) == 1) ? -frameLlr[i] : frameLlr[i];
      if (m == 0 || metric > bestMetric) begin
        best = m;
        bestMetric = metric;
      end
    end
    return best;
  endfunction

  task automatic encodeFrame(input int msg, input int mag);
    for (int i = 0; i < 20; i++) frameLlr[i] = (codeBit(msg, i) == 1) ? -mag : mag;
  endtask

  task automatic randomFrame();
    for (int i = 0; i < 20; i++) frameLlr[i] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic waitLoadReady(input string name);
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (!sReady && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    if (!sReady) reportTimeout(name);
  endtask

  task automatic strobeLength(input int len);
    waitLoadReady("waitStrobe");
    codeLength = 4'(len);
    codeLengthValid = 1'b1;
    @(posedge clk);
    #1;
    codeLengthValid = 1'b0;
    if (len >= 1 && len <= 13) benchA = len;
  endtask

  task automatic sendBeat(input int value, input logic last);
    sTdata = 8'(value);
    sTlast = last;
    sTvalid = 1'b1;
    waitLoadReady("waitBeat");
    @(posedge clk);
    #1;
    sTvalid = 1'b0;
    sTlast = 1'b0;
  endtask

  task automatic applyStimulus(input int expMsg);
    expBeat_t e;
    for (int k = 0; k < benchA; k++) begin
      e.data = expMsg[k];
      e.last = (k == benchA - 1);
      expQ.push_back(e);
    end
    for (int i = 0; i < 20; i++) sendBeat(frameLlr[i], i == 19);
  endtask

  task automatic waitDrain(input string name);
    int cyc;
    cyc = 0;
    while (expQ.size() != 0 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput(name, expQ.size(), 0);
  endtask

  task automatic pulseReset(input string tag);
    @(negedge clk);
    #2;
    arst = 1'b1;
    #1;
    checkOutput({tag, "_sReady"}, sReady, 0);
    checkOutput({tag, "_mValid"}, mTvalid, 0);
    checkOutput({tag, "_mData"}, mTdata, 0);
    checkOutput({tag, "_mLast"}, mTlast, 0);
    expQ.delete();
    prevPending = 1'b0;
    benchA = 13;
    @(posedge clk);
    #1;
    arst = 1'b0;
  endtask

  // Downstream ready pattern: always, 20 low / 10 high, or random.
  initial begin
    mReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        1: begin
          mReady = (readyPhase >= 20);
          readyPhase = (readyPhase + 1) % 30;
        end
        2: mReady = 1'($urandom_range(0, 1));
        default: mReady = 1'b1;
      endcase
    end
  end

  // Monitor: compares each handshaked bit with the scoreboard and checks stability while stalled.
  initial begin
    expBeat_t e;
    forever begin
      @(negedge clk);
      if (arst) begin
        prevPending = 1'b0;
      end else begin
        if (prevPending) begin
          checkOutput("stallValid", mTvalid, 1);
          checkOutput("stallData", mTdata, prevData);
          checkOutput("stallLast", mTlast, prevLast);
        end
        if (mTvalid && mReady) begin
          prevPending = 1'b0;
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedBeat: got data %0d with empty scoreboard", mTdata);
          end else begin
            e = expQ.pop_front();
            checkOutput("bitData", mTdata, e.data);
            checkOutput("bitLast", mTlast, e.last);
          end
        end else if (mTvalid) begin
          prevPending = 1'b1;
          prevData = mTdata;
          prevLast = mTlast;
        end else begin
          prevPending = 1'b0;
        end
      end
    end
  end

  initial begin
    int msg, cyc, p0, p1, p2;
    arst = 1'b1;
    codeLength = 4'd0;
    codeLengthValid = 1'b0;
    sTdata = 8'd0;
    sTvalid = 1'b0;
    sTlast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_sReady", sReady, 0);
    checkOutput("reset_mValid", mTvalid, 0);
    checkOutput("reset_mData", mTdata, 0);
    checkOutput("reset_mLast", mTlast, 0);
    arst = 1'b0;

    $display("[TB] A=1 with +127 and -127 frames");
    strobeLength(1);
    for (int i = 0; i < 20; i++) frameLlr[i] = 127;
    applyStimulus(0);
    for (int i = 0; i < 20; i++) frameLlr[i] = -127;
    applyStimulus(1);

    $display("[TB] A=13 clean codeword 0x1555");
    strobeLength(13);
    encodeFrame(13'h1555, 100);
    applyStimulus(13'h1555);

    $display("[TB] A=5 all-zero LLRs, invalid lengths ignored");
    strobeLength(5);
    strobeLength(15);
    strobeLength(0);
    for (int i = 0; i < 20; i++) frameLlr[i] = 0;
    applyStimulus(0);

    $display("[TB] A=13 noisy codeword");
    strobeLength(13);
    msg = int'($urandom_range(0, 8191));
    encodeFrame(msg, 100);
    p0 = int'($urandom_range(0, 6));
    p1 = int'($urandom_range(7, 13));
    p2 = int'($urandom_range(14, 19));
    frameLlr[p0] = (frameLlr[p0] > 0) ? -20 : 20;
    frameLlr[p1] = (frameLlr[p1] > 0) ? -20 : 20;
    frameLlr[p2] = (frameLlr[p2] > 0) ? -20 : 20;
    applyStimulus(modelDecode(13));

    $display("[TB] back-to-back A=1..13 with 20/10 backpressure");
    readyMode = 1;
    for (int a = 1; a <= 13; a++) begin
      strobeLength(a);
      randomFrame();
      applyStimulus(modelDecode(a));
    end

    $display("[TB] random lengths and random backpressure");
    readyMode = 2;
    for (int f = 0; f < 4; f++) begin
      strobeLength(int'($urandom_range(1, 9)));
      strobeLength(int'($urandom_range(14, 15)));
      randomFrame();
      applyStimulus(modelDecode(benchA));
    end
    waitDrain("drainBeforeReset");

    $display("[TB] reset during SEARCH");
    readyMode = 0;
    strobeLength(6);
    randomFrame();
    applyStimulus(modelDecode(6));
    repeat (5) @(posedge clk);
    pulseReset("searchReset");

    $display("[TB] reset during OUTPUT");
    readyMode = 1;
    strobeLength(6);
    randomFrame();
    applyStimulus(modelDecode(6));
    cyc = 0;
    while (expQ.size() > 4 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    if (expQ.size() > 4) reportTimeout("waitOutputReset");
    pulseReset("outputReset");

    $display("[TB] post-reset frame decodes with default A=13");
    readyMode = 0;
    msg = int'($urandom_range(0, 8191));
    encodeFrame(msg, 100);
    applyStimulus(msg);
    waitDrain("finalDrain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
